// File: rtl/mem_port_responder_if.sv
// CPU request/response and SRAM-side signals of one memory port.
// misalign_err exists only when MEM_RESP_MISALIGN_EN is defined.
interface mem_port_responder_if #(
    parameter int AW = 14
);
    logic          req_read;
    logic          req_write;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic [2:0]    req_core_type;
    logic [31:0]   rsp_rdata;
    logic          rsp_stall;
    logic          sram_cs;
    logic          sram_oe;
    logic [3:0]    sram_web;
    logic [AW-1:0] sram_a;
    logic [31:0]   sram_di;
    logic [31:0]   sram_do;
`ifdef MEM_RESP_MISALIGN_EN
    logic          misalign_err;

    modport master (
        output req_read, req_write, req_addr, req_wdata, req_core_type, sram_do,
        input  rsp_rdata, rsp_stall, sram_cs, sram_oe, sram_web, sram_a, sram_di, misalign_err
    );
    modport slave (
        input  req_read, req_write, req_addr, req_wdata, req_core_type, sram_do,
        output rsp_rdata, rsp_stall, sram_cs, sram_oe, sram_web, sram_a, sram_di, misalign_err
    );
`else
    modport master (
        output req_read, req_write, req_addr, req_wdata, req_core_type, sram_do,
        input  rsp_rdata, rsp_stall, sram_cs, sram_oe, sram_web, sram_a, sram_di
    );
    modport slave (
        input  req_read, req_write, req_addr, req_wdata, req_core_type, sram_do,
        output rsp_rdata, rsp_stall, sram_cs, sram_oe, sram_web, sram_a, sram_di
    );
`endif
endinterface

// File: rtl/mem_port_responder.sv
// Memory-port responder: one SRAM strobe per CPU request, stalling the core for
// LATENCY+1 cycles. Optional misalignment checking via MEM_RESP_MISALIGN_EN.
module mem_port_responder #(
    parameter int LATENCY = 2,
    parameter int AW      = 14
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    localparam logic [3:0] LAST = 4'(LATENCY - 1);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          accept, finish;
    logic [AW-1:0] word_q;
    logic [1:0]    lane_q;
    logic [2:0]    type_q;
    logic          write_q;
    logic [31:0]   wdata_q, rdata_q;
    logic [3:0]    lane_mask;
    logic          misaligned, strobe, wr_strobe, rd_strobe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_read || bus.req_write) begin
                    accept  = 1'b1;
                    state_d = ACCESS;
                    cnt_d   = '0;
                end
            end
            ACCESS: begin
                if (cnt_q == LAST) begin
                    finish  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Write wins when both request lines are high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q  <= '0;
            lane_q  <= '0;
            type_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                word_q  <= bus.req_addr[AW+1:2];
                lane_q  <= bus.req_addr[1:0];
                type_q  <= bus.req_core_type;
                write_q <= bus.req_write;
                wdata_q <= bus.req_wdata;
            end
            if (finish && !write_q) begin
                rdata_q <= misaligned ? 32'h0 : bus.sram_do;
            end
        end
    end

    always_comb begin
        lane_mask = 4'b0000;
        case (type_q)
            3'd1:    lane_mask = lane_q[1] ? 4'b0011 : 4'b1100;
            3'd2:    lane_mask = ~(4'b0001 << lane_q);
            default: lane_mask = 4'b0000;
        endcase
    end

`ifdef MEM_RESP_MISALIGN_EN
    always_comb begin
        misaligned = 1'b0;
        case (type_q)
            3'd1:    misaligned = lane_q[0];
            3'd2:    misaligned = 1'b0;
            default: misaligned = (lane_q != 2'b00);
        endcase
    end

    assign bus.misalign_err = (state_q == RESP) && misaligned;
`else
    assign misaligned = 1'b0;
`endif

    // Strobes are decoded from state so reset removes them immediately.
    assign strobe    = (state_q == ACCESS) && (cnt_q == 4'd0);
    assign wr_strobe = strobe && write_q && !misaligned;
    assign rd_strobe = strobe && !write_q;

    assign bus.sram_cs   = wr_strobe || rd_strobe;
    assign bus.sram_oe   = rd_strobe;
    assign bus.sram_web  = wr_strobe ? lane_mask : 4'b1111;
    assign bus.sram_a    = word_q;
    assign bus.sram_di   = wdata_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_stall = !rst && ((state_q == IDLE) ? (bus.req_read || bus.req_write)
                                                      : (state_q == ACCESS));
endmodule

// File: tb/tb_mem_port_responder.sv
// Scoreboard bench for mem_port_responder: a LATENCY=2 instance for the main
// traffic and a LATENCY=4 instance for the mid-access reset scenario.
module tb_mem_port_responder;
    localparam int LAT2 = 2;
    localparam int LAT4 = 4;
    localparam int AW   = 14;

    typedef struct {
        logic          is_read;
        logic [31:0]   rdata;
        logic [3:0]    web;
        logic [AW-1:0] a;
        logic [31:0]   di;
        int            strobes;
        logic          mis;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic rst4;
    int   tests = 0;
    int   failures = 0;

    exp_t        sb2[$];
    logic [31:0] sb4[$];
    exp_t        e2;
    logic [31:0] e4;

    logic [31:0] mem2 [0:255];
    logic [31:0] mem4 [0:255];
    logic [31:0] do2 = 32'h0;
    logic [31:0] do4 = 32'h0;

    mem_port_responder_if #(.AW(AW)) bus2 ();
    mem_port_responder_if #(.AW(AW)) bus4 ();

    mem_port_responder #(.LATENCY(LAT2), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus2));
    mem_port_responder #(.LATENCY(LAT4), .AW(AW)) dut4 (.clk(clk), .rst(rst4), .bus(bus4));

    always #5 clk = ~clk;

    assign bus2.sram_do = do2;
    assign bus4.sram_do = do4;

    function automatic logic [31:0] mergeLanes(input logic [31:0] old, input logic [31:0] di,
                                               input logic [3:0] web);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (!web[i]) r[i*8 +: 8] = di[i*8 +: 8];
        return r;
    endfunction

    // Behavioural synchronous SRAMs: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (bus2.sram_cs) begin
            if (bus2.sram_oe) do2 <= mem2[bus2.sram_a[7:0]];
            mem2[bus2.sram_a[7:0]] <= mergeLanes(mem2[bus2.sram_a[7:0]], bus2.sram_di, bus2.sram_web);
        end
        if (bus4.sram_cs) begin
            if (bus4.sram_oe) do4 <= mem4[bus4.sram_a[7:0]];
            mem4[bus4.sram_a[7:0]] <= mergeLanes(mem4[bus4.sram_a[7:0]], bus4.sram_di, bus4.sram_web);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [2:0] ctype, input bit hold,
                                 input logic [31:0] exp_rdata, input logic [3:0] exp_web,
                                 input int exp_strobes, input logic exp_mis);
        exp_t e;
        e.is_read = rd && !wr;
        e.rdata   = exp_rdata;
        e.web     = exp_web;
        e.a       = addr[AW+1:2];
        e.di      = wdata;
        e.strobes = exp_strobes;
        e.mis     = exp_mis;
        sb2.push_back(e);
        @(posedge clk); #1;
        bus2.req_read      = rd;
        bus2.req_write     = wr;
        bus2.req_addr      = addr;
        bus2.req_wdata     = wdata;
        bus2.req_core_type = ctype;
        if (hold) repeat (LAT2 + 2) @(posedge clk);
        else @(posedge clk);
        #1;
        bus2.req_read  = 1'b0;
        bus2.req_write = 1'b0;
        if (hold) begin
            @(negedge clk);
            checkOutput("no re-accept after RESP", 32'(bus2.rsp_stall), 32'h0);
        end else begin
            repeat (LAT2) @(posedge clk);
        end
    endtask

    task automatic drive4(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata);
        sb4.push_back(exp_rdata);
        @(posedge clk); #1;
        bus4.req_read      = rd;
        bus4.req_write     = wr;
        bus4.req_addr      = addr;
        bus4.req_wdata     = wdata;
        bus4.req_core_type = 3'd0;
        @(posedge clk); #1;
        bus4.req_read  = 1'b0;
        bus4.req_write = 1'b0;
        repeat (LAT4 + 1) @(posedge clk);
    endtask

    // Monitor for the LATENCY=2 port: a falling stall marks the response cycle.
    initial begin
        logic          prev = 1'b0;
        int            stall_cnt = 0;
        int            cs_cnt = 0;
        logic [3:0]    cap_web = 4'hF;
        logic [AW-1:0] cap_a = '0;
        logic          cap_oe = 1'b0;
        logic [31:0]   cap_di = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0; stall_cnt = 0; cs_cnt = 0; cap_web = 4'hF;
            end else begin
                if (bus2.rsp_stall) stall_cnt++;
                if (bus2.sram_cs || bus2.sram_web != 4'hF) begin
                    if (bus2.sram_cs) cs_cnt++;
                    cap_web = bus2.sram_web;
                    cap_a   = bus2.sram_a;
                    cap_oe  = bus2.sram_oe;
                    cap_di  = bus2.sram_di;
                end
                if (prev && !bus2.rsp_stall) begin
                    if (sb2.size() == 0) begin
                        checkOutput("unexpected response", 32'(sb2.size()), 32'h1);
                    end else begin
                        e2 = sb2.pop_front();
                        checkOutput("stall cycles", 32'(stall_cnt), 32'(LAT2 + 1));
                        checkOutput("cs strobes", 32'(cs_cnt), 32'(e2.strobes));
                        checkOutput("sram_web", 32'(cap_web), 32'(e2.web));
                        checkOutput("sram_oe", 32'(cap_oe), 32'(e2.is_read && e2.strobes > 0));
                        if (e2.strobes > 0) checkOutput("sram_a", 32'(cap_a), 32'(e2.a));
                        if (!e2.is_read && e2.strobes > 0) checkOutput("sram_di", cap_di, e2.di);
                        checkOutput("rsp_rdata", bus2.rsp_rdata, e2.rdata);
`ifdef MEM_RESP_MISALIGN_EN
                        checkOutput("misalign_err", 32'(bus2.misalign_err), 32'(e2.mis));
`endif
                    end
                    stall_cnt = 0; cs_cnt = 0; cap_web = 4'hF; cap_oe = 1'b0;
                end
                prev = bus2.rsp_stall;
            end
        end
    end

    // Monitor for the LATENCY=4 port; reset discards any partial transaction.
    initial begin
        logic prev = 1'b0;
        int   stall_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst4) begin
                prev = 1'b0; stall_cnt = 0;
            end else begin
                if (bus4.rsp_stall) stall_cnt++;
                if (prev && !bus4.rsp_stall) begin
                    if (sb4.size() == 0) begin
                        checkOutput("unexpected response L4", 32'(sb4.size()), 32'h1);
                    end else begin
                        e4 = sb4.pop_front();
                        checkOutput("stall cycles L4", 32'(stall_cnt), 32'(LAT4 + 1));
                        checkOutput("rsp_rdata L4", bus4.rsp_rdata, e4);
                    end
                    stall_cnt = 0;
                end
                prev = bus4.rsp_stall;
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem2[i] = 32'h0;
            mem4[i] = 32'h0;
        end
        rst = 1'b1; rst4 = 1'b1;
        bus2.req_read = 1'b0; bus2.req_write = 1'b0; bus2.req_addr = '0;
        bus2.req_wdata = '0; bus2.req_core_type = '0;
        bus4.req_read = 1'b0; bus4.req_write = 1'b0; bus4.req_addr = '0;
        bus4.req_wdata = '0; bus4.req_core_type = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; rst4 = 1'b0;
        @(negedge clk);
        checkOutput("reset rsp_rdata", bus2.rsp_rdata, 32'h0);
        checkOutput("reset rsp_stall", 32'(bus2.rsp_stall), 32'h0);
        checkOutput("reset sram_cs", 32'(bus2.sram_cs), 32'h0);
        checkOutput("reset sram_oe", 32'(bus2.sram_oe), 32'h0);
        checkOutput("reset sram_web", 32'(bus2.sram_web), 32'hF);
        checkOutput("reset sram_a", 32'(bus2.sram_a), 32'h0);
        checkOutput("reset sram_di", bus2.sram_di, 32'h0);

        applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd0, 1'b0, 32'h0,        4'b0000, 1, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0,        3'd0, 1'b0, 32'hDEADBEEF, 4'b1111, 1, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h13, 32'hAA000000, 3'd2, 1'b0, 32'hDEADBEEF, 4'b0111, 1, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h12, 32'h77660000, 3'd1, 1'b0, 32'hDEADBEEF, 4'b0011, 1, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h10, 32'h00001122, 3'd1, 1'b0, 32'hDEADBEEF, 4'b1100, 1, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0,        3'd0, 1'b0, 32'h77661122, 4'b1111, 1, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h20, 32'h12345678, 3'd0, 1'b0, 32'h77661122, 4'b0000, 1, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h20, 32'h0,        3'd0, 1'b1, 32'h12345678, 4'b1111, 1, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h13, 32'h0,        3'd2, 1'b0, 32'h77661122, 4'b1111, 1, 1'b0);
`ifdef MEM_RESP_MISALIGN_EN
        applyStimulus(1'b0, 1'b1, 32'h11, 32'h00FFFF00, 3'd1, 1'b0, 32'h77661122, 4'b1111, 0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h12, 32'h0,        3'd0, 1'b0, 32'h0,        4'b1111, 1, 1'b1);
`endif

        drive4(1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 32'h0);
        drive4(1'b1, 1'b0, 32'h40, 32'h0,        32'hCAFEF00D);
        @(posedge clk); #1;
        bus4.req_read = 1'b1; bus4.req_addr = 32'h40;
        @(posedge clk); #1;
        bus4.req_read = 1'b0;
        @(posedge clk); #2;
        rst4 = 1'b1;
        #1;
        checkOutput("mid-access reset stall", 32'(bus4.rsp_stall), 32'h0);
        checkOutput("mid-access reset rdata", bus4.rsp_rdata, 32'h0);
        checkOutput("mid-access reset cs", 32'(bus4.sram_cs), 32'h0);
        @(negedge clk);
        #1 rst4 = 1'b0;
        @(negedge clk);
        checkOutput("idle after reset stall", 32'(bus4.rsp_stall), 32'h0);
        drive4(1'b1, 1'b0, 32'h40, 32'h0, 32'hCAFEF00D);

        repeat (4) @(posedge clk);
        checkOutput("scoreboard drained L2", 32'(sb2.size()), 32'h0);
        checkOutput("scoreboard drained L4", 32'(sb4.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
